// File: rtl/cntry_car_detector.sv
// Country-road vehicle detector: synchronises and debounces the arrival and departure loops and keeps a saturating count of waiting cars.
// Optional macro DEPART_GATE_EN: count departures only while cntry_sig is GREEN or YELLOW.

module cntry_car_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic rise
);
    typedef enum logic [1:0] {S_LO, P_HI, S_HI, P_LO} state_t;

    localparam logic [7:0] LOAD = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state;
    logic [1:0] sync;
    logic [7:0] cnt;
    logic       level;

    assign level = sync[1];

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync  <= '0;
            state <= S_LO;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            case (state)
                S_LO: if (level) begin
                    state <= P_HI;
                    cnt   <= LOAD;
                end
                P_HI: begin
                    if (!level)           state <= S_LO;
                    else if (cnt == 8'd0) state <= S_HI;
                    else                  cnt   <= cnt - 8'd1;
                end
                S_HI: if (!level) begin
                    state <= P_LO;
                    cnt   <= LOAD;
                end
                P_LO: begin
                    if (level)            state <= S_HI;
                    else if (cnt == 8'd0) state <= S_LO;
                    else                  cnt   <= cnt - 8'd1;
                end
                default: state <= S_LO;
            endcase
        end
    end

    // Decoded from the accepting transition so the car counter updates on the same edge.
    assign rise = (state == P_HI) && level && (cnt == 8'd0);
endmodule

module cntry_car_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUEUE_W         = 4
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               loop_arrive,
    input  logic               loop_depart,
    input  logic [1:0]         cntry_sig,
    output logic               car_on_cntry_rd,
    output logic [QUEUE_W-1:0] car_count,
    output logic               overflow,
    output logic               phantom
);
    localparam logic [QUEUE_W-1:0] MAX_COUNT = {QUEUE_W{1'b1}};

    logic [1:0] raw;
    logic [1:0] rise;

    assign raw = {loop_depart, loop_arrive};

    for (genvar g = 0; g < 2; g++) begin : g_loop
        cntry_car_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .clear (clear),
            .raw   (raw[g]),
            .rise  (rise[g])
        );
    end

    logic a, d, d_drop;
    assign a = rise[0];

`ifdef DEPART_GATE_EN
    logic gate_open;
    assign gate_open = (cntry_sig == 2'd1) || (cntry_sig == 2'd2);
    assign d         = rise[1] & gate_open;
    assign d_drop    = rise[1] & ~gate_open;
`else
    logic unused_sig;
    assign unused_sig = ^cntry_sig;
    assign d          = rise[1];
    assign d_drop     = 1'b0;
`endif

    logic [QUEUE_W-1:0] next_count;
    logic               set_ovf, set_ph;

    // An arrival and a departure on the same edge pair off, even at count 0.
    always_comb begin
        next_count = car_count;
        set_ovf    = 1'b0;
        set_ph     = d_drop;
        case ({a, d})
            2'b10: begin
                if (car_count == MAX_COUNT) set_ovf    = 1'b1;
                else                        next_count = car_count + 1'b1;
            end
            2'b01: begin
                if (car_count == '0) set_ph     = 1'b1;
                else                 next_count = car_count - 1'b1;
            end
            default: next_count = car_count;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            car_count       <= '0;
            car_on_cntry_rd <= 1'b0;
            overflow        <= 1'b0;
            phantom         <= 1'b0;
        end else begin
            car_count       <= next_count;
            car_on_cntry_rd <= (next_count != '0);
            overflow        <= overflow | set_ovf;
            phantom         <= phantom | set_ph;
        end
    end
endmodule

// File: tb/tb_cntry_car_detector.sv
// Bench for cntry_car_detector: event table with scoreboard queue plus hand sequences for glitch, latency and async clear.
module tb_cntry_car_detector;
    localparam int QW = 4;
`ifdef DEPART_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif
    localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;

    logic          clk = 1'b0;
    logic          clear = 1'b0;
    logic          loop_arrive = 1'b0;
    logic          loop_depart = 1'b0;
    logic [1:0]    cntry_sig = RED;
    logic          car_on_cntry_rd;
    logic [QW-1:0] car_count;
    logic          overflow;
    logic          phantom;

    cntry_car_detector #(.DEBOUNCE_CYCLES(4), .QUEUE_W(QW)) dut (
        .clk             (clk),
        .clear           (clear),
        .loop_arrive     (loop_arrive),
        .loop_depart     (loop_depart),
        .cntry_sig       (cntry_sig),
        .car_on_cntry_rd (car_on_cntry_rd),
        .car_count       (car_count),
        .overflow        (overflow),
        .phantom         (phantom)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         arr;
        bit         dep;
        logic [1:0] sig;
        int         cnt;
        bit         car;
        bit         ovf;
        bit         ph;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input bit car, input bit o, input bit p);
        check({tag, ".count"},   int'(car_count), c);
        check({tag, ".car"},     int'(car_on_cntry_rd), int'(car));
        check({tag, ".ovf"},     int'(overflow), int'(o));
        check({tag, ".phantom"}, int'(phantom), int'(p));
    endtask

    function automatic vec_t mk(bit a, bit d, logic [1:0] s, int c, bit car, bit o, bit p);
        vec_t v;
        v.arr = a; v.dep = d; v.sig = s; v.cnt = c; v.car = car; v.ovf = o; v.ph = p;
        return v;
    endfunction

    // Hold the loop(s) for 8 edges, let the falling edge settle, then score.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        @(posedge clk); #1;
        loop_arrive = v.arr;
        loop_depart = v.dep;
        cntry_sig   = v.sig;
        exp_q.push_back(v);
        repeat (8) @(posedge clk);
        #1;
        loop_arrive = 1'b0;
        loop_depart = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: queue empty at vector %0d", idx);
        end else begin
            e = exp_q.pop_front();
            check_all($sformatf("vec%0d", idx), e.cnt, e.car, e.ovf, e.ph);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        clear = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("por", 0, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;

        // 3-cycle glitch must never be counted
        @(posedge clk); #1 loop_arrive = 1'b1;
        repeat (3) @(posedge clk);
        #1 loop_arrive = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("glitch.count", int'(car_count), 0);
            check("glitch.car", int'(car_on_cntry_rd), 0);
        end

        // Arrival latency: raw rises before E0, count updates at E6
        @(posedge clk); #1 loop_arrive = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                check("lat.E5.count", int'(car_count), 0);
                check("lat.E5.car", int'(car_on_cntry_rd), 0);
            end
            if (k == 6) begin
                check("lat.E6.count", int'(car_count), 1);
                check("lat.E6.car", int'(car_on_cntry_rd), 1);
            end
        end
        repeat (3) @(posedge clk);
        #1 loop_arrive = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("lat.hold.count", int'(car_count), 1);
        check("lat.hold.car", int'(car_on_cntry_rd), 1);

        do_reset();

        tbl.push_back(mk(1, 0, RED,    1, 1, 0, 0));
        tbl.push_back(mk(1, 0, RED,    2, 1, 0, 0));
        tbl.push_back(mk(1, 0, RED,    3, 1, 0, 0));
        tbl.push_back(mk(0, 1, GREEN,  2, 1, 0, 0));
        tbl.push_back(mk(0, 1, GREEN,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, GREEN,  0, 0, 0, 0));
        tbl.push_back(mk(1, 1, GREEN,  0, 0, 0, 0));
        tbl.push_back(mk(1, 0, GREEN,  1, 1, 0, 0));
        tbl.push_back(mk(1, 0, GREEN,  2, 1, 0, 0));
        tbl.push_back(mk(1, 1, GREEN,  2, 1, 0, 0));
        tbl.push_back(mk(0, 1, GREEN,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, RED,    GATE ? 1 : 0, GATE, 0, GATE));
        tbl.push_back(mk(0, 1, GREEN,  0, 0, 0, 1));
        tbl.push_back(mk(0, 1, YELLOW, 0, 0, 0, 1));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, RED, (i + 1 > 15) ? 15 : i + 1, 1, i == 15, 1));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], i);

        // Async clear in the middle of an arrival debounce
        @(posedge clk); #1 loop_arrive = 1'b1;
        repeat (4) @(posedge clk);
        #2 clear = 1'b0;
        #1;
        check_all("midclr", 0, 1'b0, 1'b0, 1'b0);
        loop_arrive = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        run_vec(mk(1, 0, RED, 1, 1, 0, 0), 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
